// File: rtl/line_mem_responder_if.sv
// Cache-to-memory 128-bit line request bus: level-held read/write request, one-cycle ready pulse.
// The cache side is the master; the line memory responder is the slave.
interface line_mem_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [31:4]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/line_mem_responder.sv
// Line-addressed memory answering each cache request with mem_ready LATENCY cycles after accept.
// No backpressure: the request is latched at accept; held requests are ignored until the FSM returns to IDLE.
module line_mem_responder #(
  parameter int LATENCY    = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  line_mem_responder_if.slave  mem,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, BUSY, READY, GUARD} state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [127:0]          wdata;
  } req_t;

  state_t       state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;
  req_t         req, req_nxt;
  logic         err_nxt;
  logic         do_access;
  logic [127:0] mem_array [2**DEPTH_LOG2];

  // Upper address bits are intentionally ignored so lines alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem.mem_addr[31:DEPTH_LOG2+4];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = req;
    err_nxt   = err;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (mem.mem_read && mem.mem_write) begin
          err_nxt = 1'b1;
        end else if (mem.mem_read || mem.mem_write) begin
          req_nxt.wr    = mem.mem_write;
          req_nxt.idx   = mem.mem_addr[DEPTH_LOG2+3:4];
          req_nxt.wdata = mem.mem_wdata;
          cnt_nxt       = 8'(LATENCY - 1);
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          do_access = 1'b1;
          state_nxt = READY;
        end
      end
      READY:   state_nxt = GUARD;
      GUARD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      req           <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      mem.mem_ready <= 1'b0;
      mem.mem_rdata <= 128'h0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      req           <= req_nxt;
      err           <= err_nxt;
      busy          <= (state_nxt != IDLE);
      mem.mem_ready <= (state_nxt == READY);
      if (do_access && !req.wr) begin
        mem.mem_rdata <= mem_array[req.idx];
      end
    end
  end

  // Storage is deliberately not reset; reset only aborts a write that has not yet committed.
  always_ff @(posedge clk) begin
    if (do_access && req.wr) begin
      mem_array[req.idx] <= req.wdata;
    end
  end

endmodule
